// File: rtl/mccpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: select codes, ALU ops,
// FSM states, instruction classes and MIPS opcode/funct values.
package mccpu_ctrl_pkg;

    localparam logic [4:0] LINK_REG = 5'd31;

    localparam logic [3:0] ALU_NOP = 4'd0,  ALU_ADD = 4'd1,  ALU_SUB  = 4'd2,
                           ALU_AND = 4'd3,  ALU_OR  = 4'd4,  ALU_SLT  = 4'd5,
                           ALU_SLTU = 4'd6, ALU_SLL = 4'd7,  ALU_NOR  = 4'd8,
                           ALU_SRL = 4'd9,  ALU_LUI = 4'd10;

    localparam logic [1:0] NPC_ALU = 2'd0, NPC_ALUOUT = 2'd1, NPC_JUMP = 2'd2, NPC_RS = 2'd3;
    localparam logic [1:0] WD_ALUOUT = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2;
    localparam logic [1:0] GPR_RD = 2'd0, GPR_RT = 2'd1, GPR_LINK = 2'd2;
    localparam logic [1:0] SRCA_PC = 2'd0, SRCA_RS = 2'd1, SRCA_SHAMT = 2'd2;
    localparam logic [1:0] SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SL2 = 2'd3;

    localparam logic [5:0] OP_R    = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                           OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_J    = 6'b000010,
                           OP_JAL  = 6'b000011, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001,
                           OP_ANDI = 6'b001100, OP_ORI  = 6'b001101, OP_SLTI = 6'b001010,
                           OP_LUI  = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                           FN_AND = 6'h24, FN_OR   = 6'h25, FN_NOR = 6'h27, FN_SLT  = 6'h2a,
                           FN_SLTU = 6'h2b, FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SLLV = 6'h04,
                           FN_SRLV = 6'h06, FN_JR  = 6'h08;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DCODE = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
    } ins_class_e;

endpackage

// File: rtl/mccpu_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and Zero in, control word out.
interface mccpu_ctrl_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, IorD, EXTOp, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, NPCOp, WDSel, GPRSel;
    logic [3:0] ALUOp;

    modport master (
        input  Op, Funct, Zero,
        output PCWrite, IRWrite, RegWrite, MemWrite, IorD, EXTOp, Illegal,
               ALUSrcA, ALUSrcB, NPCOp, WDSel, GPRSel, ALUOp
    );
    modport slave (
        output Op, Funct, Zero,
        input  PCWrite, IRWrite, RegWrite, MemWrite, IorD, EXTOp, Illegal,
               ALUSrcA, ALUSrcB, NPCOp, WDSel, GPRSel, ALUOp
    );
endinterface

// File: rtl/mccpu_decode.sv
// Combinational Op/Funct lookup: instruction class, EXE-stage ALU op,
// shamt-as-A flag and immediate sign-extend flag.
module mccpu_decode
    import mccpu_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ins_class_e cls,
    output logic [3:0] alu_op,
    output logic       shamt_a,
    output logic       sext
);
    always_comb begin
        cls     = C_ILL;
        alu_op  = ALU_ADD;
        shamt_a = 1'b0;
        sext    = 1'b1;
        case (op)
            OP_R: begin
                cls = C_R;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:  begin alu_op = ALU_SLL; shamt_a = 1'b1; end
                    FN_SRL:  begin alu_op = ALU_SRL; shamt_a = 1'b1; end
                    FN_SLLV:         alu_op = ALU_SLL;
                    FN_SRLV:         alu_op = ALU_SRL;
                    FN_JR:           cls = C_JR;
                    default:         cls = C_ILL;
                endcase
            end
            OP_ADDI, OP_ADDIU: cls = C_IALU;
            OP_SLTI: begin cls = C_IALU; alu_op = ALU_SLT; end
            OP_ANDI: begin cls = C_IALU; alu_op = ALU_AND; sext = 1'b0; end
            OP_ORI:  begin cls = C_IALU; alu_op = ALU_OR;  sext = 1'b0; end
            OP_LUI:  begin cls = C_IALU; alu_op = ALU_LUI; sext = 1'b0; end
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  begin cls = C_BEQ; alu_op = ALU_SUB; end
            OP_BNE:  begin cls = C_BNE; alu_op = ALU_SUB; end
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end
endmodule

// File: rtl/mccpu_ctrl.sv
// Multi-cycle control FSM (FETCH/DCODE/EXE/MEM/WB) driving the datapath
// control word; outputs are combinational from state, IR fields and Zero.
module mccpu_ctrl
    import mccpu_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    mccpu_ctrl_if.master bus
);
    state_e     state, state_nxt;
    ins_class_e cls;
    logic [3:0] dec_alu;
    logic       dec_shamt, dec_sext;

    mccpu_decode u_dec (
        .op      (bus.Op),
        .funct   (bus.Funct),
        .cls     (cls),
        .alu_op  (dec_alu),
        .shamt_a (dec_shamt),
        .sext    (dec_sext)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = S_FETCH;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IorD     = 1'b0;
        bus.EXTOp    = 1'b0;
        bus.Illegal  = 1'b0;
        bus.ALUSrcA  = SRCA_PC;
        bus.ALUSrcB  = SRCB_RT;
        bus.NPCOp    = NPC_ALU;
        bus.WDSel    = WD_ALUOUT;
        bus.GPRSel   = GPR_RD;
        bus.ALUOp    = ALU_NOP;
        // Reset held low: state already reads FETCH, so gate everything to idle.
        if (rstn) begin
            case (state)
                S_FETCH: begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.ALUSrcB = SRCB_4;
                    bus.ALUOp   = ALU_ADD;
                    state_nxt   = S_DCODE;
                end
                S_DCODE: begin
                    // Branch target precomputed into ALUOut for EXE.
                    bus.ALUSrcB = SRCB_IMM_SL2;
                    bus.EXTOp   = 1'b1;
                    bus.ALUOp   = ALU_ADD;
                    case (cls)
                        C_J:   begin bus.PCWrite = 1'b1; bus.NPCOp = NPC_JUMP; end
                        C_JAL: begin
                            bus.PCWrite  = 1'b1;
                            bus.NPCOp    = NPC_JUMP;
                            bus.RegWrite = 1'b1;
                            bus.GPRSel   = GPR_LINK;
                            bus.WDSel    = WD_PC;
                        end
                        C_JR:  begin bus.PCWrite = 1'b1; bus.NPCOp = NPC_RS; end
                        C_ILL: bus.Illegal = 1'b1;
                        default: state_nxt = S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (cls)
                        C_R: begin
                            bus.ALUSrcA = dec_shamt ? SRCA_SHAMT : SRCA_RS;
                            bus.ALUOp   = dec_alu;
                            state_nxt   = S_WB;
                        end
                        C_IALU: begin
                            bus.ALUSrcA = SRCA_RS;
                            bus.ALUSrcB = SRCB_IMM;
                            bus.EXTOp   = dec_sext;
                            bus.ALUOp   = dec_alu;
                            state_nxt   = S_WB;
                        end
                        C_LW, C_SW: begin
                            bus.ALUSrcA = SRCA_RS;
                            bus.ALUSrcB = SRCB_IMM;
                            bus.EXTOp   = 1'b1;
                            bus.ALUOp   = ALU_ADD;
                            state_nxt   = S_MEM;
                        end
                        C_BEQ, C_BNE: begin
                            bus.ALUSrcA = SRCA_RS;
                            bus.ALUOp   = ALU_SUB;
                            bus.NPCOp   = NPC_ALUOUT;
                            bus.PCWrite = (cls == C_BEQ) ? bus.Zero : ~bus.Zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.IorD = 1'b1;
                    if (cls == C_SW) bus.MemWrite = 1'b1;
                    if (cls == C_LW) state_nxt = S_WB;
                end
                S_WB: begin
                    case (cls)
                        C_LW:   begin bus.RegWrite = 1'b1; bus.WDSel = WD_MDR; bus.GPRSel = GPR_RT; end
                        C_IALU: begin bus.RegWrite = 1'b1; bus.GPRSel = GPR_RT; end
                        C_R:    bus.RegWrite = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mccpu_ctrl.sv
// Random instruction stream against a per-step table model of the control word.
module tb_mccpu_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    mccpu_ctrl_if bus ();
    mccpu_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    localparam int K_R = 0, K_SH = 1, K_IS = 2, K_IZ = 3, K_LW = 4, K_SW = 5, K_BEQ = 6,
                   K_BNE = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_ILL = 11;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         kd;
        logic [3:0] al;
    } ins_t;

    ins_t tbl[$];

    task automatic add_ins(input logic [5:0] op, input logic [5:0] fn, input int kd, input logic [3:0] al);
        ins_t e;
        e.op = op; e.fn = fn; e.kd = kd; e.al = al;
        tbl.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic pcw, irw, rw, mw, iord,
                                       input logic [1:0] sa, sb, input logic [3:0] al,
                                       input logic ext, input logic [1:0] npc, wd, gpr,
                                       input logic ill);
        return {11'd0, pcw, irw, rw, mw, iord, sa, sb, al, ext, npc, wd, gpr, ill};
    endfunction

    function automatic logic [31:0] obs();
        return {11'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.IorD,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.EXTOp, bus.NPCOp, bus.WDSel,
                bus.GPRSel, bus.Illegal};
    endfunction

    function automatic int ncyc(input int kd);
        case (kd)
            K_LW:                         return 5;
            K_R, K_SH, K_IS, K_IZ, K_SW:  return 4;
            K_BEQ, K_BNE:                 return 3;
            default:                      return 2;
        endcase
    endfunction

    // Expected control word at step k (0 = first cycle of the instruction).
    function automatic logic [31:0] model(input ins_t e, input logic z, input int k);
        if (k == 0) return pk(1,1,0,0,0, 0,1, 4'd1, 0, 0,0,0, 0);
        if (k == 1) begin
            case (e.kd)
                K_J:   return pk(1,0,0,0,0, 0,3, 4'd1, 1, 2,0,0, 0);
                K_JAL: return pk(1,0,1,0,0, 0,3, 4'd1, 1, 2,2,2, 0);
                K_JR:  return pk(1,0,0,0,0, 0,3, 4'd1, 1, 3,0,0, 0);
                K_ILL: return pk(0,0,0,0,0, 0,3, 4'd1, 1, 0,0,0, 1);
                default: return pk(0,0,0,0,0, 0,3, 4'd1, 1, 0,0,0, 0);
            endcase
        end
        if (k == 2) begin
            case (e.kd)
                K_R:   return pk(0,0,0,0,0, 1,0, e.al, 0, 0,0,0, 0);
                K_SH:  return pk(0,0,0,0,0, 2,0, e.al, 0, 0,0,0, 0);
                K_IS:  return pk(0,0,0,0,0, 1,2, e.al, 1, 0,0,0, 0);
                K_IZ:  return pk(0,0,0,0,0, 1,2, e.al, 0, 0,0,0, 0);
                K_LW, K_SW: return pk(0,0,0,0,0, 1,2, 4'd1, 1, 0,0,0, 0);
                K_BEQ: return pk(z,0,0,0,0, 1,0, 4'd2, 0, 1,0,0, 0);
                default: return pk(!z,0,0,0,0, 1,0, 4'd2, 0, 1,0,0, 0);
            endcase
        end
        if (k == 3) begin
            case (e.kd)
                K_LW: return pk(0,0,0,0,1, 0,0, 4'd0, 0, 0,0,0, 0);
                K_SW: return pk(0,0,0,1,1, 0,0, 4'd0, 0, 0,0,0, 0);
                K_R, K_SH: return pk(0,0,1,0,0, 0,0, 4'd0, 0, 0,0,0, 0);
                default: return pk(0,0,1,0,0, 0,0, 4'd0, 0, 0,0,1, 0);
            endcase
        end
        return pk(0,0,1,0,0, 0,0, 4'd0, 0, 0,1,1, 0);
    endfunction

    task automatic run_ins(input ins_t e);
        logic z;
        bus.Op    = e.op;
        bus.Funct = e.fn;
        for (int k = 0; k < ncyc(e.kd); k++) begin
            z = 1'($urandom_range(1, 0));
            bus.Zero = z;
            @(negedge clk);
            chk($sformatf("op%h_fn%h_k%0d", e.op, e.fn, k), obs(), model(e, z, k));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ins_t e;
        add_ins(6'h00, 6'h20, K_R, 4'd1);   add_ins(6'h00, 6'h21, K_R, 4'd1);
        add_ins(6'h00, 6'h22, K_R, 4'd2);   add_ins(6'h00, 6'h23, K_R, 4'd2);
        add_ins(6'h00, 6'h24, K_R, 4'd3);   add_ins(6'h00, 6'h25, K_R, 4'd4);
        add_ins(6'h00, 6'h27, K_R, 4'd8);   add_ins(6'h00, 6'h2a, K_R, 4'd5);
        add_ins(6'h00, 6'h2b, K_R, 4'd6);   add_ins(6'h00, 6'h00, K_SH, 4'd7);
        add_ins(6'h00, 6'h02, K_SH, 4'd9);  add_ins(6'h00, 6'h04, K_R, 4'd7);
        add_ins(6'h00, 6'h06, K_R, 4'd9);   add_ins(6'h00, 6'h08, K_JR, 4'd0);
        add_ins(6'h08, 6'h15, K_IS, 4'd1);  add_ins(6'h09, 6'h3a, K_IS, 4'd1);
        add_ins(6'h0a, 6'h01, K_IS, 4'd5);  add_ins(6'h0c, 6'h11, K_IZ, 4'd3);
        add_ins(6'h0d, 6'h20, K_IZ, 4'd4);  add_ins(6'h0f, 6'h07, K_IZ, 4'd10);
        add_ins(6'h23, 6'h10, K_LW, 4'd0);  add_ins(6'h2b, 6'h04, K_SW, 4'd0);
        add_ins(6'h04, 6'h00, K_BEQ, 4'd0); add_ins(6'h05, 6'h08, K_BNE, 4'd0);
        add_ins(6'h02, 6'h20, K_J, 4'd0);   add_ins(6'h03, 6'h00, K_JAL, 4'd0);
        add_ins(6'h3f, 6'h20, K_ILL, 4'd0); add_ins(6'h00, 6'h3f, K_ILL, 4'd0);
        add_ins(6'h01, 6'h00, K_ILL, 4'd0); add_ins(6'h00, 6'h03, K_ILL, 4'd0);

        bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Op = 6'($urandom);
            @(negedge clk);
            chk("reset_idle", obs(), 32'd0);
        end
        @(posedge clk);
        #1 rstn = 1'b1;

        // Directed pass over every table entry, then a random stream.
        for (int i = 0; i < tbl.size(); i++) run_ins(tbl[i]);

        // Reset dropped in the middle of EXE of an add.
        e = tbl[0];
        bus.Op = e.op; bus.Funct = e.fn;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_add_k%0d", k), obs(), model(e, 1'b0, k));
            if (k < 2) begin @(posedge clk); #1; end
        end
        #2 rstn = 1'b0;
        #1 chk("mid_rst_idle", obs(), 32'd0);
        @(negedge clk);
        chk("mid_rst_hold", obs(), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        run_ins(tbl[20]);

        for (int i = 0; i < 300; i++) run_ins(tbl[$urandom_range(tbl.size() - 1, 0)]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
